// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants made while fetch is waiting; saturates at the limit.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = mem_arb_pkg::STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != Limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_limit = (r_cnt == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between instruction fetch and data accesses,
// data first, with fetch forced through after a bounded run of data grants.
module mem_port_arbiter #(
  parameter int unsigned DATA_W       = mem_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W       = mem_arb_pkg::ADDR_W,
  parameter int unsigned STARVE_LIMIT = mem_arb_pkg::STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_byte,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  import mem_arb_pkg::*;

  arb_state_t        r_state, w_state_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic              r_mem_byte, w_mem_byte_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
  logic              r_if_ready, w_if_ready_nxt;
  logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_nxt;
  logic              r_dm_ready, w_dm_ready_nxt;
  logic              r_cancel_pending, w_cancel_pending_nxt;
  logic              w_starve_inc, w_starve_clr, w_at_limit;

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc     (w_starve_inc),
    .clr     (w_starve_clr),
    .at_limit(w_at_limit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_mem_req        <= 1'b0;
      r_mem_we         <= 1'b0;
      r_mem_byte       <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wdata      <= '0;
      r_if_rdata       <= '0;
      r_if_ready       <= 1'b0;
      r_dm_rdata       <= '0;
      r_dm_ready       <= 1'b0;
      r_cancel_pending <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_mem_req        <= w_mem_req_nxt;
      r_mem_we         <= w_mem_we_nxt;
      r_mem_byte       <= w_mem_byte_nxt;
      r_mem_addr       <= w_mem_addr_nxt;
      r_mem_wdata      <= w_mem_wdata_nxt;
      r_if_rdata       <= w_if_rdata_nxt;
      r_if_ready       <= w_if_ready_nxt;
      r_dm_rdata       <= w_dm_rdata_nxt;
      r_dm_ready       <= w_dm_ready_nxt;
      r_cancel_pending <= w_cancel_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_mem_req_nxt        = r_mem_req;
    w_mem_we_nxt         = r_mem_we;
    w_mem_byte_nxt       = r_mem_byte;
    w_mem_addr_nxt       = r_mem_addr;
    w_mem_wdata_nxt      = r_mem_wdata;
    w_if_rdata_nxt       = r_if_rdata;
    w_if_ready_nxt       = 1'b0;
    w_dm_rdata_nxt       = r_dm_rdata;
    w_dm_ready_nxt       = 1'b0;
    w_cancel_pending_nxt = r_cancel_pending;
    w_starve_inc         = 1'b0;
    w_starve_clr         = 1'b0;

    case (r_state)
      IDLE: begin
        w_cancel_pending_nxt = 1'b0;
        if (if_req && (!dm_req || w_at_limit)) begin
          w_state_nxt     = FETCH;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_byte_nxt  = 1'b0;
          w_mem_addr_nxt  = if_addr;
          w_mem_wdata_nxt = '0;
          w_starve_clr    = 1'b1;
        end else if (dm_req) begin
          w_state_nxt     = DATA;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = dm_we;
          w_mem_byte_nxt  = dm_byte;
          w_mem_addr_nxt  = dm_addr;
          w_mem_wdata_nxt = dm_wdata;
          // Only a data grant that actually makes fetch wait counts toward starvation.
          w_starve_inc    = if_req;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          w_state_nxt          = IDLE;
          w_mem_req_nxt        = 1'b0;
          w_cancel_pending_nxt = 1'b0;
          // A redirect seen on the ack cycle itself still discards the result.
          if (!r_cancel_pending && !if_cancel) begin
            w_if_rdata_nxt = mem_rdata;
            w_if_ready_nxt = 1'b1;
          end
        end else if (if_cancel) begin
          w_cancel_pending_nxt = 1'b1;
        end
      end
      DATA: begin
        if (mem_ack) begin
          w_state_nxt    = IDLE;
          w_mem_req_nxt  = 1'b0;
          w_dm_rdata_nxt = mem_rdata;
          w_dm_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_byte  = r_mem_byte;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_ready  = r_if_ready;
  assign dm_rdata  = r_dm_rdata;
  assign dm_ready  = r_dm_ready;

endmodule
